// File: rtl/ram_pattern_loader.sv
// Writes a selectable data pattern over an inclusive, wrapping RAM address range on a start edge.
// Define RAM_PATTERN_LOADER_VERIFY_EN to add a read-back pass that flags mismatches on o_err.
module ram_pattern_loader #(
  parameter int unsigned G_RAM_ADDR_WIDTH = 8,
  parameter int unsigned G_RAM_DATA_WIDTH = 8,
  parameter int unsigned G_SEL_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_addr,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_stop_addr,
  input  logic [G_SEL_WIDTH-1:0]      i_sel,
  input  logic                        i_start,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_rdata,
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
  output logic                        o_err,
`endif
  output logic                        o_done
);

  localparam int unsigned AW = G_RAM_ADDR_WIDTH;
  localparam int unsigned DW = G_RAM_DATA_WIDTH;
  localparam int unsigned SW = G_SEL_WIDTH;
  localparam logic [DW-1:0] ALT55 = DW'({DW{2'b01}});

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic [AW-1:0]   start_addr_q, start_addr_d;
  logic [AW-1:0]   stop_addr_q, stop_addr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            me_q, me_d, we_q, we_d, done_q, done_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            start_fire;
  logic            last_word;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_pat;

  // Data word for write index k at address a.
  function automatic logic [DW-1:0] pattern(input logic [SW-1:0] sel,
                                            input logic [AW-1:0] k,
                                            input logic [AW-1:0] a);
    logic [DW-1:0] p;
    p = '0;
    case (sel)
      SW'(0):  p = DW'(k);
      SW'(1):  p = ~DW'(k);
      SW'(2):  p = '0;
      SW'(3):  p = '1;
      SW'(4):  p = k[0] ? ~ALT55 : ALT55;
      SW'(5):  p = DW'(1) << (32'(k) % DW);
      SW'(6):  p = DW'(a);
      default: p = '0;
    endcase
    return p;
  endfunction

  assign start_fire = i_start & ~start_q;
  assign last_word  = (idx_q == AW'(stop_addr_q - start_addr_q));
  assign cur_addr   = AW'(start_addr_q + idx_q);
  assign cur_pat    = pattern(sel_q, idx_q, cur_addr);

`ifdef RAM_PATTERN_LOADER_VERIFY_EN
  logic            rd_pend_q, rd_pend_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic            err_q, err_d;
  assign o_err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^i_rdata;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    stop_addr_d  = stop_addr_q;
    sel_d        = sel_q;
    idx_d        = idx_q;
    me_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
    rd_pend_d    = 1'b0;
    exp_d        = exp_q;
    err_d        = err_q;
    if (rd_pend_q && (i_rdata != exp_q)) err_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_fire) begin
          start_addr_d = i_ram_start_addr;
          stop_addr_d  = i_ram_stop_addr;
          sel_d        = i_sel;
          idx_d        = '0;
          state_d      = S_WRITE;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
          err_d        = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        me_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = cur_addr;
        wdata_d = cur_pat;
        if (last_word) begin
          idx_d = '0;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = AW'(idx_q + AW'(1));
        end
      end
      S_VERIFY: begin
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
        me_d      = 1'b1;
        addr_d    = cur_addr;
        rd_pend_d = 1'b1;
        exp_d     = cur_pat;
        if (last_word) state_d = S_DONE;
        else           idx_d   = AW'(idx_q + AW'(1));
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
        // Hold off the done pulse until the final read word has been compared.
        if (!rd_pend_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`else
        done_d  = 1'b1;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      start_addr_q <= '0;
      stop_addr_q  <= '0;
      sel_q        <= '0;
      idx_q        <= '0;
      me_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
      rd_pend_q    <= 1'b0;
      exp_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= i_start;
      start_addr_q <= start_addr_d;
      stop_addr_q  <= stop_addr_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      me_q         <= me_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
      rd_pend_q    <= rd_pend_d;
      exp_q        <= exp_d;
      err_q        <= err_d;
`endif
    end
  end

  assign o_me    = me_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_ram_pattern_loader.sv
// Scoreboard bench for ram_pattern_loader: expected write/done events are queued at start
// and checked by an independent monitor on the falling edge.
module tb_ram_pattern_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] start_addr, stop_addr, sel, addr, wdata, rdata;
  logic       start, me, we, done;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
  logic       err;
`endif

  typedef struct {
    logic       is_done;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (me && we) mem[addr] <= wdata;
  assign rdata = mem[addr];

  ram_pattern_loader dut (
    .clk(clk), .rst(rst),
    .i_ram_start_addr(start_addr), .i_ram_stop_addr(stop_addr),
    .i_sel(sel), .i_start(start),
    .o_me(me), .o_we(we), .o_addr(addr), .o_wdata(wdata),
    .i_rdata(rdata),
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
    .o_err(err),
`endif
    .o_done(done)
  );

  // Reference pattern from the selection rules, in plain integer arithmetic.
  function automatic logic [7:0] ref_pat(int s, int k, int a);
    case (s)
      0:       return 8'(k % 256);
      1:       return 8'(255 - (k % 256));
      2:       return 8'h00;
      3:       return 8'hFF;
      4:       return (k % 2 == 1) ? 8'hAA : 8'h55;
      5:       return 8'(1 << (k % 8));
      6:       return 8'(a);
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: every write (or done pulse) the DUT presents is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && (done || (me && we))) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got done=%0b me=%0b we=%0b addr=%02h data=%02h cyc=%0d, want no event",
                 done, me, we, addr, wdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done !== e.is_done || me !== !e.is_done || we !== !e.is_done ||
            addr !== e.addr || wdata !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL event: got done=%0b me=%0b we=%0b addr=%02h data=%02h cyc=%0d, want done=%0b addr=%02h data=%02h cyc=%0d",
                   done, me, we, addr, wdata, cyc, e.is_done, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue a start edge and queue the full expected response.
  task automatic start_op(int s, int e, int sl, bit hold);
    int n0, cnt, a;
    exp_t x;
    step();
    start_addr = 8'(s);
    stop_addr  = 8'(e);
    sel        = 8'(sl);
    start      = 1'b1;
    n0  = cyc + 1;
    cnt = ((e - s + 256) % 256) + 1;
    a   = s;
    for (int k = 0; k < cnt; k++) begin
      a = (s + k) % 256;
      x.is_done = 1'b0; x.addr = 8'(a); x.data = ref_pat(sl, k, a); x.cyc = n0 + 1 + k;
      sb.push_back(x);
    end
    x.is_done = 1'b1;
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
    x.cyc = n0 + 2 * cnt + 2;
`else
    x.cyc = n0 + cnt + 1;
`endif
    sb.push_back(x);
    step();
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for all queued events, scrambling config inputs to prove they were latched.
  task automatic drain(int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      start_addr = 8'($urandom);
      stop_addr  = 8'($urandom);
      sel        = 8'($urandom);
      step();
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d events pending, want 0", sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  task automatic check_idle_zero(string nm);
    n_cmp++;
    if ({me, we, addr, wdata, done} !== 19'd0) begin
      n_bad++;
      $display("FAIL %s: got me=%0b we=%0b addr=%02h data=%02h done=%0b, want all zero",
               nm, me, we, addr, wdata, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; stop_addr = '0; sel = '0;
    repeat (3) step();
    check_idle_zero("reset_state");
    rst = 1'b0;
    step();

    start_op(8'h10, 8'h13, 0, 1'b0); drain(100);
    start_op(8'hFE, 8'h01, 6, 1'b0); drain(100);
    start_op(8'h20, 8'h20, 5, 1'b0); drain(100);
    start_op(8'h00, 8'h03, 4, 1'b0); drain(100);
    start_op(8'h30, 8'h37, 1, 1'b0); drain(100);
    start_op(8'h00, 8'h00, 3, 1'b0); drain(100);

    // Start held high across completion must not retrigger.
    start_op(8'h40, 8'h45, 3, 1'b1);
    drain(100);
    repeat (5) step();
    start = 1'b0;
    repeat (3) step();

    // A second rising edge during WRITE is ignored.
    start_op(8'h50, 8'h5F, 2, 1'b0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    drain(100);

    // Reset mid-write aborts without a done pulse.
    start_op(8'h80, 8'hBF, 0, 1'b0);
    repeat (5) step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    check_idle_zero("reset_mid_write");
    rst = 1'b0;
    repeat (70) step();
    start_op(8'h80, 8'h83, 6, 1'b0); drain(100);

    // Randomized operations, including occasional out-of-range selects and a full wrap.
    for (int t = 0; t < 25; t++) begin
      int s, span, sl;
      s    = $urandom_range(0, 255);
      span = (t == 7) ? 255 : $urandom_range(0, 40);
      sl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      start_op(s, (s + span) % 256, sl, 1'b0);
      drain(700);
`ifdef RAM_PATTERN_LOADER_VERIFY_EN
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL verify_err: got %0b want 0", err);
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
